// File: rtl/result_matrix_serializer_if.sv
// ----------------------------------------------------------------------------
// result_matrix_serializer_if
// Purpose : Element stream leaving the result matrix serializer. Each beat
//           carries one element together with its row/column position and an
//           end-of-matrix flag, and moves on a valid/ready handshake.
// Signals :
//   out_valid  beat present (serializer -> consumer)
//   out_ready  consumer accepts the current beat (consumer -> serializer)
//   out_data   element value, ELEM_W bits
//   out_row    row index of the beat
//   out_col    column index of the beat
//   out_last   final beat of the matrix
// Modports: master = serializer side, slave = consumer side.
// ----------------------------------------------------------------------------
interface result_matrix_serializer_if #(
    parameter int ELEM_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_matrix_serializer.sv
// ----------------------------------------------------------------------------
// result_matrix_serializer
// Purpose : Captures the concatenated DIMxDIM result matrix of the matrix
//           multiplier on a start pulse and streams its elements out in
//           row-major order, one element per accepted beat, then pulses done.
// Ports   :
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      one-cycle capture request, honoured only while idle
//   matrix_in  element (r,c) at bits [ELEM_W*(DIM*r+c) +: ELEM_W]
//   busy       high while streaming and during the done cycle
//   done       one-cycle pulse after the final beat is accepted
//   out_if     element stream (master modport of result_matrix_serializer_if)
// Option  : define SERIALIZER_CHECKSUM_EN to append a beat carrying the
//           modulo-2^ELEM_W sum of all captured elements, tagged row=col=3.
// ----------------------------------------------------------------------------
module result_matrix_serializer #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ELEM_W*DIM*DIM-1:0]  matrix_in,
    output logic                       busy,
    output logic                       done,
    result_matrix_serializer_if.master out_if
);
    localparam int         NUM_ELEMS = DIM * DIM;
    localparam int         MAT_W     = ELEM_W * NUM_ELEMS;
    localparam logic [1:0] LAST_IDX  = 2'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MAT_W-1:0]  matrix_q, matrix_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [ELEM_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        next_row;
    logic [1:0]        next_col;
    logic              next_last;
    logic [ELEM_W-1:0] next_data;

    // Selects element (r,c) of a packed matrix. Out-of-range positions read
    // as zero rather than indexing past the vector.
    function automatic logic [ELEM_W-1:0] elem_at(
        input logic [MAT_W-1:0] m,
        input logic [1:0]       r,
        input logic [1:0]       c
    );
        logic [ELEM_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (i == int'(r) * DIM + int'(c)) begin
                v = m[ELEM_W*i +: ELEM_W];
            end
        end
        return v;
    endfunction

`ifdef SERIALIZER_CHECKSUM_EN
    localparam logic [1:0] CSUM_IDX = 2'd3;
    logic [ELEM_W-1:0] checksum;

    // Wrapping sum over the captured copy, so it is stable for the whole
    // stream regardless of what happens on matrix_in.
    always_comb begin
        checksum = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            checksum = checksum + matrix_q[ELEM_W*i +: ELEM_W];
        end
    end
`endif

    // Position and contents of the beat that follows the one currently
    // presented. Outputs are registered, so the next beat is prepared here
    // and loaded on the accepting edge.
    always_comb begin
        next_row = row_q;
        next_col = col_q;
        if (col_q == LAST_IDX) begin
            next_col = 2'd0;
            next_row = row_q + 2'd1;
        end else begin
            next_col = col_q + 2'd1;
        end
`ifdef SERIALIZER_CHECKSUM_EN
        if ((row_q == LAST_IDX) && (col_q == LAST_IDX)) begin
            next_row = CSUM_IDX;
            next_col = CSUM_IDX;
        end
        next_last = (next_row == CSUM_IDX);
        next_data = (next_row == CSUM_IDX) ? checksum
                                           : elem_at(matrix_q, next_row, next_col);
`else
        next_last = (next_row == LAST_IDX) && (next_col == LAST_IDX);
        next_data = elem_at(matrix_q, next_row, next_col);
`endif
    end

    // Next-state logic. The beat registers only change on capture or on an
    // accepted beat, which keeps them stable through any length of stall.
    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        row_d    = row_q;
        col_d    = col_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d  = SEND;
                    matrix_d = matrix_in;
                    row_d    = 2'd0;
                    col_d    = 2'd0;
                    data_d   = matrix_in[ELEM_W-1:0];
                    last_d   = 1'b0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            SEND: begin
                if (valid_q && out_if.out_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        row_d   = 2'd0;
                        col_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        row_d  = next_row;
                        col_d  = next_col;
                        data_d = next_data;
                        last_d = next_last;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single state register for the FSM and every registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            row_q    <= row_d;
            col_q    <= col_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_result_matrix_serializer.sv
// ----------------------------------------------------------------------------
// tb_result_matrix_serializer
// Purpose : Directed and randomized stimulus for result_matrix_serializer,
//           compared against a row-major beat list built from the captured
//           matrix. Honours SERIALIZER_CHECKSUM_EN the same way the design
//           does, so it can be built with or without the checksum beat.
// ----------------------------------------------------------------------------
module tb_result_matrix_serializer;
    localparam int ELEM_W = 8;
    localparam int DIM    = 3;
    localparam int N      = DIM * DIM;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int BEATS  = N + 1;
`else
    localparam int BEATS  = N;
`endif
    localparam int MAX_CYCLES = 300;

    typedef struct {
        logic [7:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [ELEM_W*N-1:0]     matrix_in = '0;
    logic                    busy;
    logic                    done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] cur_elems [N];
    beat_t      expq [$];

    result_matrix_serializer_if #(.ELEM_W(ELEM_W)) bus ();

    result_matrix_serializer #(
        .ELEM_W (ELEM_W),
        .DIM    (DIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .matrix_in (matrix_in),
        .busy      (busy),
        .done      (done),
        .out_if    (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compares one observed value with the value the model requires.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the matrix read out in row-major order, position k
    // lands at row k/DIM, column k%DIM, and the last element (or the checksum
    // beat when enabled) carries the last flag.
    task automatic build_expected();
        beat_t      b;
        logic [7:0] sum;
        expq.delete();
        sum = 8'd0;
        for (int k = 0; k < N; k++) begin
            b.data = cur_elems[k];
            b.row  = 2'(k / DIM);
            b.col  = 2'(k % DIM);
            b.last = (k == N - 1);
            sum    = sum + cur_elems[k];
            expq.push_back(b);
        end
`ifdef SERIALIZER_CHECKSUM_EN
        expq[N-1].last = 1'b0;
        b.data = sum;
        b.row  = 2'd3;
        b.col  = 2'd3;
        b.last = 1'b1;
        expq.push_back(b);
`endif
    endtask

    task automatic random_matrix_in();
        matrix_in = 72'({$urandom(), $urandom(), $urandom()});
    endtask

    // Runs one matrix through the serializer.
    //   ready_mode 0: ready always high; 1: 3-cycle stall on beat 5; 2: random
    //   inject     : scramble matrix_in every beat and pulse start with all-FF
    //   abort_at   : beat index at which reset is asserted (-1 for none)
    task automatic apply_stimulus(input int ready_mode, input bit inject,
                                  input int abort_at);
        int idx;
        int cycles;
        int stall;
        build_expected();
        for (int k = 0; k < N; k++) matrix_in[ELEM_W*k +: ELEM_W] = cur_elems[k];
        start         = 1'b1;
        bus.out_ready = (ready_mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check_output("busy_after_start", 32'(busy), 32'd1);

        idx    = 0;
        cycles = 0;
        stall  = 0;
        while (idx < BEATS && cycles < MAX_CYCLES) begin
            check_output($sformatf("valid_b%0d", idx), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("data_b%0d", idx), 32'(bus.out_data), 32'(expq[idx].data));
            check_output($sformatf("row_b%0d", idx), 32'(bus.out_row), 32'(expq[idx].row));
            check_output($sformatf("col_b%0d", idx), 32'(bus.out_col), 32'(expq[idx].col));
            check_output($sformatf("last_b%0d", idx), 32'(bus.out_last), 32'(expq[idx].last));
            check_output($sformatf("done_b%0d", idx), 32'(done), 32'd0);

            if (abort_at == idx) begin
                start = 1'b0;
                #2 rst = 1'b0;
                #1;
                check_output("abort_valid", 32'(bus.out_valid), 32'd0);
                check_output("abort_data", 32'(bus.out_data), 32'd0);
                check_output("abort_row", 32'(bus.out_row), 32'd0);
                check_output("abort_col", 32'(bus.out_col), 32'd0);
                check_output("abort_last", 32'(bus.out_last), 32'd0);
                check_output("abort_busy", 32'(busy), 32'd0);
                check_output("abort_done", 32'(done), 32'd0);
                bus.out_ready = 1'b1;
                tick();
                tick();
                rst = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check_output("post_abort_done", 32'(done), 32'd0);
                    check_output("post_abort_valid", 32'(bus.out_valid), 32'd0);
                end
                return;
            end

            if (inject) begin
                if (idx == 3) begin
                    start     = 1'b1;
                    matrix_in = '1;
                end else begin
                    start = 1'b0;
                    random_matrix_in();
                end
            end

            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    if (idx == 4 && stall < 3) begin
                        bus.out_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase

            tick();
            cycles++;
            if (bus.out_ready) idx++;
        end
        start = 1'b0;
        if (idx < BEATS) check_output("stream_timeout", 32'(idx), 32'(BEATS));

        check_output("done_pulse", 32'(done), 32'd1);
        check_output("done_busy", 32'(busy), 32'd1);
        check_output("done_valid", 32'(bus.out_valid), 32'd0);

        // A start during the done cycle must not be taken.
        start = 1'b1;
        random_matrix_in();
        tick();
        start = 1'b0;
        check_output("idle_done", 32'(done), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);
        check_output("idle_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_output("no_restart_valid", 32'(bus.out_valid), 32'd0);
        check_output("no_restart_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        $display("[TB] starting result_matrix_serializer bench");
        bus.out_ready = 1'b0;

        // Reset held from time zero, then released with no start.
        #1;
        check_output("rst_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("idle_no_start_busy", 32'(busy), 32'd0);
            check_output("idle_no_start_valid", 32'(bus.out_valid), 32'd0);
            check_output("idle_no_start_data", 32'(bus.out_data), 32'd0);
        end

        // Basic stream of 1..9.
        for (int k = 0; k < N; k++) cur_elems[k] = 8'(k + 1);
        apply_stimulus(0, 1'b0, -1);

        // Backpressure on beat 5.
        apply_stimulus(1, 1'b0, -1);

        // Start with all-FF during beat 4 and matrix_in scrambled throughout.
        apply_stimulus(0, 1'b1, -1);

        // Reset during beat 6, then a fresh matrix streams from (0,0).
        apply_stimulus(0, 1'b0, 5);
        for (int k = 0; k < N; k++) cur_elems[k] = 8'(8'hA0 + k);
        apply_stimulus(0, 1'b0, -1);

`ifdef SERIALIZER_CHECKSUM_EN
        // Checksum wraps: 0xF0 + 0x20 + 7 = 0x117 -> 0x17.
        cur_elems[0] = 8'hF0;
        cur_elems[1] = 8'h20;
        for (int k = 2; k < N; k++) cur_elems[k] = 8'h01;
        apply_stimulus(0, 1'b0, -1);
`endif

        // Randomized matrices with random ready and input scrambling.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) cur_elems[k] = 8'($urandom_range(0, 255));
            apply_stimulus(2, 1'(t % 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
